// File: rtl/control_unpool_2x2.sv
// Nearest-neighbour 2x2 unpooling: each pooled pixel is emitted twice per row,
// and each row is replayed once from a line buffer to double the height.
module control_unpool_2x2 #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              in_ready,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              out_ready,
    output logic              eol_out,
    output logic              eof_out
);

    localparam int HALF = WIDTH / 2;
    localparam int ROWS = HEIGHT / 2;
    localparam int CW   = $clog2(HALF + 1);
    localparam int RCW  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0]  COL_LAST  = CW'(HALF);
    localparam logic [RCW-1:0] RCOL_LAST = RCW'(HALF - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      col, col_nxt;
    logic [RCW-1:0]     rcol, rcol_nxt;
    logic [RW-1:0]      row, row_nxt;
    logic               dup, dup_nxt;
    logic               hold_valid, hold_valid_nxt;
    logic [DATA_W-1:0]  hold;
    logic [DATA_W-1:0]  line_buf [HALF];
    logic               load;
    logic               in_xfer;
    logic               out_xfer;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign in_ready = rst && (state == FILL) && (col < COL_LAST)
                      && (!hold_valid || (out_ready && dup));
    assign valid_out = (state == REPLAY) ? 1'b1 : hold_valid;
    assign data_out  = (state == REPLAY) ? line_buf[rcol] : hold;
    assign eol_out   = valid_out && dup
                       && (((state == FILL) && (col == COL_LAST))
                           || ((state == REPLAY) && (rcol == RCOL_LAST)));
    assign eof_out   = eol_out && (state == REPLAY) && (row == ROW_LAST);

    assign in_xfer  = valid_in && in_ready;
    assign out_xfer = valid_out && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FILL;
            col        <= '0;
            rcol       <= '0;
            row        <= '0;
            dup        <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            rcol       <= rcol_nxt;
            row        <= row_nxt;
            dup        <= dup_nxt;
            hold_valid <= hold_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hold                     <= data_in;
            line_buf[col[RCW-1:0]]   <= data_in;
        end
    end

    always_comb begin
        state_nxt      = state;
        col_nxt        = col;
        rcol_nxt       = rcol;
        row_nxt        = row;
        dup_nxt        = dup;
        hold_valid_nxt = hold_valid;
        load           = 1'b0;
        case (state)
            FILL: begin
                if (out_xfer && dup && (col == COL_LAST)) begin
                    state_nxt      = REPLAY;
                    rcol_nxt       = '0;
                    dup_nxt        = 1'b0;
                    hold_valid_nxt = 1'b0;
                end else if (in_xfer) begin
                    // May coincide with the second copy leaving: no bubble.
                    load           = 1'b1;
                    hold_valid_nxt = 1'b1;
                    dup_nxt        = 1'b0;
                    col_nxt        = col + CW'(1);
                end else if (out_xfer) begin
                    if (!dup) begin
                        dup_nxt = 1'b1;
                    end else begin
                        hold_valid_nxt = 1'b0;
                    end
                end
            end
            REPLAY: begin
                if (out_xfer) begin
                    dup_nxt = !dup;
                    if (dup) begin
                        if (rcol == RCOL_LAST) begin
                            state_nxt = FILL;
                            col_nxt   = '0;
                            rcol_nxt  = '0;
                            row_nxt   = (row == ROW_LAST) ? '0 : row + RW'(1);
                        end else begin
                            rcol_nxt = rcol + RCW'(1);
                        end
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

endmodule

// File: tb/tb_control_unpool_2x2.sv
// Directed bench for control_unpool_2x2: a 4x4 instance and an 8x2 instance
// share one driver and one monitor, selected by sel.
module tb_control_unpool_2x2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       valid_drv = 1'b0;
    logic [7:0] data_drv = 8'h00;
    logic       out_ready = 1'b1;

    always #5 clk = ~clk;

    logic       in_ready_a, valid_out_a, eol_out_a, eof_out_a;
    logic       in_ready_b, valid_out_b, eol_out_b, eof_out_b;
    logic [7:0] data_out_a, data_out_b;
    logic       valid_in_a, valid_in_b;

    assign valid_in_a = valid_drv && !sel;
    assign valid_in_b = valid_drv && sel;

    control_unpool_2x2 #(.WIDTH(4), .HEIGHT(4), .DATA_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in_a), .data_in(data_drv),
        .in_ready(in_ready_a), .valid_out(valid_out_a), .data_out(data_out_a),
        .out_ready(out_ready), .eol_out(eol_out_a), .eof_out(eof_out_a)
    );

    control_unpool_2x2 #(.WIDTH(8), .HEIGHT(2), .DATA_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in_b), .data_in(data_drv),
        .in_ready(in_ready_b), .valid_out(valid_out_b), .data_out(data_out_b),
        .out_ready(out_ready), .eol_out(eol_out_b), .eof_out(eof_out_b)
    );

    logic       mv, mir, meol, meof;
    logic [7:0] md;
    assign mv   = sel ? valid_out_b : valid_out_a;
    assign mir  = sel ? in_ready_b  : in_ready_a;
    assign meol = sel ? eol_out_b   : eol_out_a;
    assign meof = sel ? eof_out_b   : eof_out_a;
    assign md   = sel ? data_out_b  : data_out_a;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] out_d[$];
    logic       out_eol[$];
    logic       out_eof[$];
    int         bub[64];
    int         rmode = 0;
    int         gap = 0;
    int         idle = 0;
    int         cyc = 0;
    logic       xfer_seen = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d = 8'h00;

    // Monitor: sampled mid-cycle, records transfers that complete at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
            xfer_seen  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(mv), 32'd1);
                check("stall_data", 32'(md), 32'(prev_d));
            end
            if (mv && (((out_d.size() / (sel ? 8 : 4)) % 2) == 1))
                check("replay_in_ready", 32'(mir), 32'd0);
            if (!mv && out_d.size() < 64)
                bub[out_d.size()]++;
            if (mv && out_ready) begin
                out_d.push_back(md);
                out_eol.push_back(meol);
                out_eof.push_back(meof);
            end
            stall_prev = mv && !out_ready;
            prev_d     = md;
            xfer_seen  = valid_drv && mir;
        end
    end

    // Driver: holds valid/data until accepted, optional idle gap between pixels.
    always @(posedge clk) begin
        #1;
        cyc++;
        out_ready = (rmode == 0) || ((cyc % 4) == 0) || ((cyc % 4) == 3);
        if (!rst) begin
            valid_drv = 1'b0;
            idle      = 0;
        end else begin
            if (xfer_seen) begin
                void'(in_q.pop_front());
                valid_drv = 1'b0;
                idle      = gap;
            end
            if (!valid_drv) begin
                if (idle > 0) begin
                    idle--;
                end else if (in_q.size() > 0) begin
                    valid_drv = 1'b1;
                    data_drv  = in_q[0];
                end
            end
        end
    end

    task automatic clear_outs();
        out_d.delete();
        out_eol.delete();
        out_eof.delete();
        foreach (bub[i]) bub[i] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid_out", 32'(mv), 32'd0);
        check("rst_in_ready", 32'(mir), 32'd0);
        check("rst_eol", 32'(meol), 32'd0);
        check("rst_eof", 32'(meof), 32'd0);
        in_q.delete();
        clear_outs();
        rst = 1'b1;
    endtask

    task automatic wait_outs(input string tag, input int n);
        int c = 0;
        while (out_d.size() < n && c < 2000) begin
            @(posedge clk); #2;
            c++;
        end
        check({tag, "_arrived"}, 32'(out_d.size() >= n), 32'd1);
    endtask

    task automatic compare(input string tag, input logic [31:0] eolm, input logic [31:0] eofm);
        wait_outs(tag, exp_q.size());
        repeat (10) @(posedge clk);
        #2;
        check({tag, "_count"}, 32'(out_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_d.size() && i < 32; i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(out_d[i]), 32'(exp_q[i]));
            check($sformatf("%s_eol%0d", tag, i), 32'(out_eol[i]), 32'(eolm[i]));
            check($sformatf("%s_eof%0d", tag, i), 32'(out_eof[i]), 32'(eofm[i]));
        end
    endtask

    initial begin
        // Basic row
        do_reset();
        in_q  = '{8'h11, 8'h22};
        exp_q = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11, 8'h11, 8'h22, 8'h22};
        compare("basic", 32'h0000_0088, 32'h0000_0000);
        check("basic_no_bubble_load", 32'(bub[2]), 32'd0);
        check("basic_no_bubble_replay", 32'(bub[4]), 32'd0);

        // Two full frames back to back
        do_reset();
        in_q  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
        exp_q = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2,
                  8'd3, 8'd3, 8'd4, 8'd4, 8'd3, 8'd3, 8'd4, 8'd4,
                  8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2,
                  8'd3, 8'd3, 8'd4, 8'd4, 8'd3, 8'd3, 8'd4, 8'd4};
        compare("frame", 32'h8888_8888, 32'h8000_8000);
        check("frame_refill_bubble", 32'(bub[8] > 0), 32'd1);
        check("frame_no_bubble_load", 32'(bub[2]), 32'd0);

        // Backpressure 1,0,0,1
        do_reset();
        rmode = 1;
        in_q  = '{8'd1, 8'd2, 8'd3, 8'd4};
        exp_q = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2,
                  8'd3, 8'd3, 8'd4, 8'd4, 8'd3, 8'd3, 8'd4, 8'd4};
        compare("bp", 32'h0000_8888, 32'h0000_8000);
        rmode = 0;

        // Upstream gaps
        do_reset();
        gap   = 4;
        in_q  = '{8'd1, 8'd2, 8'd3, 8'd4};
        compare("gap", 32'h0000_8888, 32'h0000_8000);
        check("gap_bubble_fill", 32'(bub[2] > 0), 32'd1);
        check("gap_bubble_fill2", 32'(bub[10] > 0), 32'd1);
        check("gap_pair_tight", 32'(bub[1]), 32'd0);
        for (int k = 4; k < 8; k++)
            check($sformatf("gap_replay_tight%0d", k), 32'(bub[k]), 32'd0);
        gap = 0;

        // Reset during REPLAY after its 2nd output
        do_reset();
        in_q = '{8'd1, 8'd2};
        wait_outs("mid", 6);
        rst = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_valid_out", 32'(mv), 32'd0);
        check("mid_rst_in_ready", 32'(mir), 32'd0);
        in_q.delete();
        clear_outs();
        rst = 1'b1;
        in_q  = '{8'h0A, 8'h0B};
        exp_q = '{8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0A, 8'h0A, 8'h0B, 8'h0B};
        compare("mid", 32'h0000_0088, 32'h0000_0000);

        // WIDTH=8, HEIGHT=2 instance
        sel = 1'b1;
        do_reset();
        in_q  = '{8'd1, 8'd2, 8'd3, 8'd4};
        exp_q = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4,
                  8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4};
        compare("w8", 32'h0000_8080, 32'h0000_8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_unpool_2x2.md
# control_unpool_2x2

Nearest-neighbour 2x2 upsampling (unpooling) stage: the inverse-direction counterpart of the 2x2 max-pooling control in the VGG16 pipeline.
- Accepts a pooled feature-map stream of WIDTH/2 pixels per row.
- Emits a full-resolution stream of WIDTH pixels per row: each input pixel is replicated horizontally, and each row is replayed vertically from an internal line buffer.
- Sits between a pooled-map producer and any consumer expecting full-width rows; valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 4: output row width in pixels; even, ≥2. Input row width is WIDTH/2.
- HEIGHT, 4: output frame height in rows; even, ≥2. Input frame height is HEIGHT/2.
- DATA_W, 8: pixel width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- valid_in  input  1  upstream pixel valid.
- data_in  input  DATA_W  upstream pixel.
- in_ready  output  1  block accepts data_in this cycle; transfer = valid_in & in_ready.
- valid_out  output  1  data_out valid.
- data_out  output  DATA_W  output pixel.
- out_ready  input  1  downstream accepts; transfer = valid_out & out_ready.
- eol_out  output  1  qualifies the last pixel of an output row.
- eof_out  output  1  qualifies the last pixel of an output frame.

## Operation
- Storage:
  - line_buf[0..WIDTH/2-1] of DATA_W bits.
  - hold register plus hold_valid.
  - dup bit: 0 = first copy, 1 = second copy.
  - col (0..WIDTH/2) and rcol (0..WIDTH/2-1) counters.
  - row counter (0..HEIGHT/2-1), counting input rows.
- Two states: FILL (even output row, consumes input) and REPLAY (odd output row, no input).
- FILL:
  - in_ready = (col < WIDTH/2) & (!hold_valid | (out_ready & dup)).
  - On input transfer:
    - hold <= data_in, hold_valid <= 1, dup <= 0.
    - line_buf[col] <= data_in, col <= col+1.
  - On output transfer with dup=0: dup <= 1; data unchanged.
  - On output transfer with dup=1 and no simultaneous input transfer: hold_valid <= 0.
  - On output transfer with dup=1 and col=WIDTH/2:
    - state <= REPLAY, rcol <= 0, dup <= 0, hold_valid <= 0.
- REPLAY:
  - in_ready = 0; valid_out = 1; data_out = line_buf[rcol].
  - On output transfer: dup toggles; when dup=1, rcol <= rcol+1.
  - On output transfer with dup=1 and rcol=WIDTH/2-1:
    - state <= FILL, col <= 0.
    - row <= (row=HEIGHT/2-1) ? 0 : row+1.
- Outputs in FILL: data_out = hold, valid_out = hold_valid.
- eol_out = valid_out & dup & ((FILL & col=WIDTH/2) | (REPLAY & rcol=WIDTH/2-1)).
- eof_out = eol_out & REPLAY & row=HEIGHT/2-1.
- Upstream must hold valid_in/data_in stable while in_ready=0. valid_in during REPLAY is ignored; nothing is lost.
- Counter widths: $clog2(WIDTH/2+1) for col; $clog2(HEIGHT/2) for row, minimum 1 bit. No overflow past the stated bounds.

## Timing
- Reset (rst=0 at an edge) sets:
  - state=FILL, col=0, rcol=0, row=0, dup=0, hold_valid=0.
  - Consequently valid_out=0, eol_out=0, eof_out=0.
  - While rst=0: in_ready=0.
  - line_buf and hold are not reset; their contents are don't-care.
- Reset mid-operation (any state) discards the partial row/frame. The first transfer after reset is treated as pixel 0 of row 0.
- Latency: an input accepted at edge N appears on data_out at cycle N+1, first copy.
- Throughput with out_ready=1:
  - 1 output per cycle; FILL accepts 1 input per 2 cycles.
  - FILL→REPLAY has no bubble.
  - REPLAY→FILL has a ≥1-cycle bubble (valid_out=0) before the first new input appears.
- Backpressure: out_ready=0 freezes data_out, valid_out, dup and all counters. in_ready falls to 0 if hold_valid=1.
- Simultaneous input transfer and dup=1 output transfer in FILL: the new pixel is loaded with no bubble.

## Test plan
(WIDTH=4, HEIGHT=4, DATA_W=8 unless noted)
- Basic row:
  - Stimulus: inputs 0x11, 0x22; out_ready=1.
  - Required: outputs 11,11,22,22 then 11,11,22,22.
  - eol_out on the 4th and 8th outputs; in_ready=0 throughout REPLAY.
- Full frame:
  - Stimulus: inputs 1,2,3,4; out_ready=1.
  - Required: 16 outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4.
  - eof_out only on the 16th; row returns to 0; a second frame repeats identically.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeating.
  - Required: same data sequence as the full-frame case; data_out stable while out_ready=0; no duplicate or dropped pixel.
- Upstream gaps:
  - Stimulus: valid_in pulsed every 5 cycles.
  - Required: valid_out=0 between copies of successive FILL pixels; REPLAY still emits 4 back-to-back outputs.
- Reset mid-REPLAY:
  - Stimulus: rst=0 for 1 cycle after the 2nd REPLAY output, then inputs 0xA, 0xB.
  - Required: valid_out=0 during reset; next outputs A,A,B,B,A,A,B,B.
- WIDTH=8, HEIGHT=2:
  - Stimulus: inputs 1..4.
  - Required: 16 outputs; eol_out on the 8th and 16th; eof_out on the 16th.
